// File: rtl/bridge_pkg.sv
// Shared types and helpers for the wide-to-narrow bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  // Widest byteenable half the helper accepts; callers zero-extend into it.
  localparam int BE_MAX = 32;

  // True when a byteenable half has no lanes enabled.
  function automatic logic half_be_empty(input logic [BE_MAX-1:0] be);
    return (be == '0);
  endfunction

endpackage

// File: rtl/bridge_split.sv
// Wide-to-narrow memory-mapped bridge: one 2*WIDTHD-bit slave access becomes
// two WIDTHD-bit master accesses, low half first. All d-side outputs and
// s_readdata are registers, so no s_* input reaches a d_* output combinationally.
//
// Handshake (both sides): a request is held stable while waitrequest is high;
// it is accepted in the cycle waitrequest is low, and read data is valid in
// that same cycle. On the s side waitrequest is low for exactly one cycle
// (DONE) per completed access; the master must drop or change its request
// after seeing it low.
module bridge_split
  import bridge_pkg::*;
#(
  parameter int WIDTHA     = 8,
  parameter int WIDTHD     = 16,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic                  clock,
  input  logic                  sreset,
  input  logic [WIDTHA-2:0]     s_address,
  input  logic [WIDTHD/4-1:0]   s_byteenable,
  input  logic [2*WIDTHD-1:0]   s_writedata,
  output logic [2*WIDTHD-1:0]   s_readdata,
  input  logic                  s_read,
  input  logic                  s_write,
  output logic                  s_waitrequest,
  output logic [WIDTHA-1:0]     d_address,
  output logic [WIDTHD/8-1:0]   d_byteenable,
  output logic [WIDTHD-1:0]     d_writedata,
  input  logic [WIDTHD-1:0]     d_readdata,
  output logic                  d_read,
  output logic                  d_write,
  input  logic                  d_waitrequest,
  output bridge_state_t         state_dbg
);

  localparam int HB = WIDTHD / 8;

  bridge_state_t      state;
  logic [WIDTHA-2:0]  addr_q;
  logic [WIDTHD-1:0]  wd_hi_q;
  logic [HB-1:0]      be_hi_q;
  logic               wr_q;
  logic [WIDTHD-1:0]  rd_lo_q;

  logic               req;
  logic [HB-1:0]      in_be_lo;
  logic [HB-1:0]      in_be_hi;
  logic               in_lo_empty;
  logic               in_hi_empty;
  logic               q_hi_empty;

  assign state_dbg = state;

  // Request decode: write wins over read; reads never issue an empty half,
  // and empty write halves are flagged for skipping.
  always_comb begin
    req         = s_read | s_write;
    in_be_lo    = s_byteenable[HB-1:0];
    in_be_hi    = s_byteenable[2*HB-1:HB];
    if (!s_write) begin
      if (in_be_lo == '0) in_be_lo = '1;
      if (in_be_hi == '0) in_be_hi = '1;
    end
    in_lo_empty = SKIP_EMPTY && s_write && half_be_empty(BE_MAX'(s_byteenable[HB-1:0]));
    in_hi_empty = SKIP_EMPTY && s_write && half_be_empty(BE_MAX'(s_byteenable[2*HB-1:HB]));
    q_hi_empty  = SKIP_EMPTY && wr_q && half_be_empty(BE_MAX'(be_hi_q));
  end

  // Bridge FSM with registered d-side outputs, s_waitrequest and read data.
  always_ff @(posedge clock) begin
    if (sreset) begin
      state         <= IDLE;
      s_waitrequest <= 1'b1;
      d_read        <= 1'b0;
      d_write       <= 1'b0;
      d_address     <= '0;
      d_byteenable  <= '0;
      d_writedata   <= '0;
      addr_q        <= '0;
      wd_hi_q       <= '0;
      be_hi_q       <= '0;
      wr_q          <= 1'b0;
      rd_lo_q       <= '0;
      s_readdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= s_address;
            wd_hi_q <= s_writedata[2*WIDTHD-1:WIDTHD];
            be_hi_q <= in_be_hi;
            wr_q    <= s_write;
            if (in_lo_empty && in_hi_empty) begin
              state         <= DONE;
              s_waitrequest <= 1'b0;
            end else if (in_lo_empty) begin
              // Only a write can skip its low half.
              state        <= HIGH;
              d_address    <= {s_address, 1'b1};
              d_byteenable <= in_be_hi;
              d_writedata  <= s_writedata[2*WIDTHD-1:WIDTHD];
              d_write      <= 1'b1;
              d_read       <= 1'b0;
            end else begin
              state        <= LOW;
              d_address    <= {s_address, 1'b0};
              d_byteenable <= in_be_lo;
              d_writedata  <= s_writedata[WIDTHD-1:0];
              d_write      <= s_write;
              d_read       <= !s_write;
            end
          end
        end
        LOW: begin
          if (!d_waitrequest) begin
            if (!wr_q) rd_lo_q <= d_readdata;
            if (q_hi_empty) begin
              state         <= DONE;
              d_read        <= 1'b0;
              d_write       <= 1'b0;
              s_waitrequest <= 1'b0;
            end else begin
              state        <= HIGH;
              d_address    <= {addr_q, 1'b1};
              d_byteenable <= be_hi_q;
              d_writedata  <= wd_hi_q;
            end
          end
        end
        HIGH: begin
          if (!d_waitrequest) begin
            if (!wr_q) s_readdata <= {d_readdata, rd_lo_q};
            state         <= DONE;
            d_read        <= 1'b0;
            d_write       <= 1'b0;
            s_waitrequest <= 1'b0;
          end
        end
        DONE: begin
          state         <= IDLE;
          s_waitrequest <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          s_waitrequest <= 1'b1;
          d_read        <= 1'b0;
          d_write       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_split.sv
// Bench for bridge_split: directed accesses with hand-computed d-side beats
// and s-side completions queued up front, checked by independent monitors.
module tb_bridge_split;
  import bridge_pkg::*;

  logic        clock = 1'b0;
  logic        sreset;
  logic [6:0]  s_address;
  logic [3:0]  s_byteenable;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        s_read;
  logic        s_write;
  logic        s_waitrequest;
  logic [7:0]  d_address;
  logic [1:0]  d_byteenable;
  logic [15:0] d_writedata;
  logic [15:0] d_readdata;
  logic        d_read;
  logic        d_write;
  logic        d_waitrequest;
  bridge_state_t state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // beat entry: {write, read, address[7:0], byteenable[1:0], writedata[15:0]}
  logic [27:0] exp_q[$];
  // completion entry: {is_read, readdata[31:0]}
  logic [32:0] cpl_q[$];

  logic [15:0] rd_mem [256];
  int stall_lo  = 0;
  int stall_hi  = 0;
  int stall_cnt = 0;

  bridge_split #(.WIDTHA(8), .WIDTHD(16), .SKIP_EMPTY(1'b1)) dut (
    .clock(clock), .sreset(sreset),
    .s_address(s_address), .s_byteenable(s_byteenable),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .d_address(d_address), .d_byteenable(d_byteenable),
    .d_writedata(d_writedata), .d_readdata(d_readdata),
    .d_read(d_read), .d_write(d_write), .d_waitrequest(d_waitrequest),
    .state_dbg(state_dbg)
  );

  // clock / narrow-side responder
  always #5 clock = ~clock;

  assign d_readdata    = rd_mem[d_address];
  assign d_waitrequest = stall_cnt < (d_address[0] ? stall_hi : stall_lo);

  always @(posedge clock) begin
    if (sreset || !(d_read || d_write) || !d_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic wr, input logic [7:0] a, input logic [1:0] be,
                           input logic [15:0] wd);
    exp_q.push_back({wr, ~wr, a, be, wd});
  endtask

  task automatic push_cpl(input logic is_rd, input logic [31:0] data);
    cpl_q.push_back({is_rd, data});
  endtask

  // d-side monitor: every presented beat (stalled or accepted) must match the head
  always @(negedge clock) begin
    if (mon_en) begin
      logic [27:0] act;
      check("rd_wr_exclusive", {63'b0, d_read && d_write}, 64'd0);
      if (state_dbg == IDLE || state_dbg == DONE)
        check("no_cmd_idle_done", {63'b0, d_read || d_write}, 64'd0);
      if (d_read || d_write) begin
        act = {d_write, d_read, d_address, d_byteenable, d_write ? d_writedata : 16'h0};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", act);
        end else begin
          check("d_beat", act, exp_q[0]);
          if (!d_waitrequest) void'(exp_q.pop_front());
        end
      end
    end
  end

  // s-side monitor: each completion pops one expected entry
  always @(negedge clock) begin
    if (mon_en && !s_waitrequest) begin
      logic [32:0] e;
      if (cpl_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_completion: got %0h expected none", s_readdata);
      end else begin
        e = cpl_q.pop_front();
        if (e[32]) check("s_readdata", s_readdata, e[31:0]);
        else check("write_cpl_state", state_dbg, DONE);
      end
    end
  end

  // driver: issue one access, hold until waitrequest low, check latency
  task automatic access(input logic wr, input logic rd, input logic [6:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int exp_lat, input string name);
    int cyc;
    bit done;
    @(negedge clock);
    s_address    = a;
    s_byteenable = be;
    s_writedata  = wd;
    s_write      = wr;
    s_read       = rd;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (!s_waitrequest) done = 1'b1;
    end
    s_read  = 1'b0;
    s_write = 1'b0;
    check({name, "_latency"}, done ? cyc : 0, exp_lat);
    @(negedge clock);
    check({name, "_wait_high_after"}, {63'b0, s_waitrequest}, 64'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) rd_mem[i] = 16'h0;
    rd_mem[8'h20] = 16'h1234;
    rd_mem[8'h21] = 16'h5678;
    rd_mem[8'h22] = 16'hCAFE;
    rd_mem[8'h23] = 16'hF00D;
    rd_mem[8'h24] = 16'h0001;
    rd_mem[8'h25] = 16'h0002;

    sreset = 1'b1;
    s_address = '0; s_byteenable = '0; s_writedata = '0;
    s_read = 1'b0; s_write = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_s_waitrequest", {63'b0, s_waitrequest}, 64'd1);
    check("rst_d_read", {63'b0, d_read}, 64'd0);
    check("rst_d_write", {63'b0, d_write}, 64'd0);
    check("rst_d_address", d_address, 64'd0);
    check("rst_s_readdata", s_readdata, 64'd0);
    check("rst_state", state_dbg, IDLE);
    sreset = 1'b0;
    mon_en = 1'b1;

    // full write
    push_beat(1'b1, 8'h0A, 2'b11, 16'hBEEF);
    push_beat(1'b1, 8'h0B, 2'b11, 16'hDEAD);
    push_cpl(1'b0, 32'h0);
    access(1'b1, 1'b0, 7'h05, 4'hF, 32'hDEADBEEF, 4, "write_full");

    // full read
    push_beat(1'b0, 8'h20, 2'b11, 16'h0);
    push_beat(1'b0, 8'h21, 2'b11, 16'h0);
    push_cpl(1'b1, 32'h56781234);
    access(1'b0, 1'b1, 7'h10, 4'hF, 32'h0, 4, "read_full");

    // read with 3 stall cycles on each beat
    stall_lo = 3; stall_hi = 3;
    push_beat(1'b0, 8'h22, 2'b11, 16'h0);
    push_beat(1'b0, 8'h23, 2'b11, 16'h0);
    push_cpl(1'b1, 32'hF00DCAFE);
    access(1'b0, 1'b1, 7'h11, 4'hF, 32'h0, 10, "read_stall");
    stall_lo = 0; stall_hi = 0;

    // read with an empty low half: low beat goes out with all lanes
    push_beat(1'b0, 8'h24, 2'b11, 16'h0);
    push_beat(1'b0, 8'h25, 2'b01, 16'h0);
    push_cpl(1'b1, 32'h00020001);
    access(1'b0, 1'b1, 7'h12, 4'b0100, 32'h0, 4, "read_partial_be");

    // write, low half empty: only the high beat
    push_beat(1'b1, 8'h0F, 2'b11, 16'hAABB);
    push_cpl(1'b0, 32'h0);
    access(1'b1, 1'b0, 7'h07, 4'b1100, 32'hAABBCCDD, 3, "write_skip_low");

    // write, both halves empty: no beats at all
    push_cpl(1'b0, 32'h0);
    access(1'b1, 1'b0, 7'h08, 4'b0000, 32'h12345678, 2, "write_skip_all");

    // write with partial enables in each half
    push_beat(1'b1, 8'h06, 2'b10, 16'h3344);
    push_beat(1'b1, 8'h07, 2'b01, 16'h1122);
    push_cpl(1'b0, 32'h0);
    access(1'b1, 1'b0, 7'h03, 4'b0110, 32'h11223344, 4, "write_partial");

    // read and write together: treated as write
    push_beat(1'b1, 8'h12, 2'b11, 16'hF00D);
    push_beat(1'b1, 8'h13, 2'b11, 16'h0BAD);
    push_cpl(1'b0, 32'h0);
    access(1'b1, 1'b1, 7'h09, 4'hF, 32'h0BADF00D, 4, "read_write_both");

    // reset while the high beat is stalled
    stall_lo = 0; stall_hi = 31;
    push_beat(1'b1, 8'h0A, 2'b11, 16'h5678);
    push_beat(1'b1, 8'h0B, 2'b11, 16'h1234);
    @(negedge clock);
    s_address = 7'h05; s_byteenable = 4'hF; s_writedata = 32'h12345678; s_write = 1'b1;
    n = 0;
    while (state_dbg != HIGH && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("reached_high", {63'b0, state_dbg == HIGH}, 64'd1);
    s_write = 1'b0;
    sreset  = 1'b1;
    @(negedge clock);
    check("midrst_d_write", {63'b0, d_write}, 64'd0);
    check("midrst_d_read", {63'b0, d_read}, 64'd0);
    check("midrst_s_waitrequest", {63'b0, s_waitrequest}, 64'd1);
    check("midrst_state", state_dbg, IDLE);
    sreset = 1'b0;
    exp_q.delete();
    stall_hi = 0;

    // read after reset completes normally
    push_beat(1'b0, 8'h20, 2'b11, 16'h0);
    push_beat(1'b0, 8'h21, 2'b11, 16'h0);
    push_cpl(1'b1, 32'h56781234);
    access(1'b0, 1'b1, 7'h10, 4'hF, 32'h0, 4, "read_after_reset");

    repeat (3) @(negedge clock);
    check("beats_left", exp_q.size(), 64'd0);
    check("cpls_left", cpl_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
